// File: rtl/y86_pkg.sv
// Shared Y86 constants for the write-back sequencer: instruction codes,
// register encodings, the sequencer state type and a one-hot register helper.
package y86_pkg;

    localparam int W     = 64;
    localparam int NREGS = 15;

    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // state | meaning
    // IDLE  | no bundle in flight, ready for a new one
    // WE    | driving the dstE/valE write
    // WM    | driving the dstM/valM write
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WE   = 2'd1,
        ST_WM   = 2'd2
    } wb_state_e;

    // One-hot scoreboard bit for an architectural register index.
    function automatic logic [NREGS-1:0] reg_bit(input logic [3:0] r);
        logic [15:0] oh;
        oh = 16'h0001 << r;
        return oh[NREGS-1:0];
    endfunction

endpackage

// File: rtl/wb_write_sequencer_if.sv
// Bundle-input, register-file write port and scoreboard signals of the
// write-back sequencer, grouped for connection between stages.
interface wb_write_sequencer_if;
    import y86_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       icode;
    logic             cnd;
    logic [3:0]       rA;
    logic [3:0]       rB;
    logic [W-1:0]     valE;
    logic [W-1:0]     valM;
    logic             wr_en;
    logic             wr_ready;
    logic [3:0]       wr_addr;
    logic [W-1:0]     wr_data;
    logic [NREGS-1:0] pending;
    logic [15:0]      retired;

    modport slave (
        input  in_valid, icode, cnd, rA, rB, valE, valM, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data, pending, retired
    );

    modport master (
        output in_valid, icode, cnd, rA, rB, valE, valM, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data, pending, retired
    );

endinterface

// File: rtl/wb_dest_decode.sv
// Maps an accepted bundle to its (at most two) destination registers.
// A destination that decodes to RNONE is reported as not valid.
module wb_dest_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic       cnd,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    output logic       dst_e_v,
    output logic [3:0] dst_e,
    output logic       dst_m_v,
    output logic [3:0] dst_m
);

    // Per-icode destination selection, then drop RNONE targets.
    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        case (icode)
            I_CMOVXX:                 dst_e = cnd ? rB : RNONE;
            I_IRMOVQ, I_OPQ:          dst_e = rB;
            I_MRMOVQ:                 dst_m = rA;
            I_CALL, I_RET, I_PUSHQ:   dst_e = RSP;
            I_POPQ: begin
                dst_e = RSP;
                dst_m = rA;
            end
            default: ;
        endcase
        dst_e_v = (dst_e != RNONE);
        dst_m_v = (dst_m != RNONE);
    end

endmodule

// File: rtl/wb_write_sequencer.sv
// Serialises write-back bundles onto the single register-file write port:
// dstE/valE first, then dstM/valM, one write per cycle, with a pending-write
// scoreboard for hazard detection and a retired-bundle counter.
module wb_write_sequencer
    import y86_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    wb_write_sequencer_if.slave  bus
);

    wb_state_e        state_q, state_d;
    logic             dst_e_v_q, dst_e_v_d;
    logic [3:0]       dst_e_q, dst_e_d;
    logic [W-1:0]     val_e_q, val_e_d;
    logic             dst_m_v_q, dst_m_v_d;
    logic [3:0]       dst_m_q, dst_m_d;
    logic [W-1:0]     val_m_q, val_m_d;
    logic [15:0]      retired_q, retired_d;

    logic             dec_e_v, dec_m_v;
    logic [3:0]       dec_e, dec_m;
    logic             in_ready_c;
    logic             accept;
    logic             wr_done;
    logic             retire_now;
    logic             retire_wr;
    wb_state_e        accept_state;

    wb_dest_decode u_dest_decode (
        .icode   (bus.icode),
        .cnd     (bus.cnd),
        .rA      (bus.rA),
        .rB      (bus.rB),
        .dst_e_v (dec_e_v),
        .dst_e   (dec_e),
        .dst_m_v (dec_m_v),
        .dst_m   (dec_m)
    );

    // Handshake: a new bundle is taken while idle or on the final write of the current one.
    always_comb begin
        wr_done      = (state_q != ST_IDLE) && bus.wr_ready;
        in_ready_c   = (state_q == ST_IDLE)
                     || ((state_q == ST_WE) && !dst_m_v_q && bus.wr_ready)
                     || ((state_q == ST_WM) && bus.wr_ready);
        accept       = bus.in_valid && in_ready_c;
        accept_state = dec_e_v ? ST_WE : (dec_m_v ? ST_WM : ST_IDLE);
        retire_now   = accept && !dec_e_v && !dec_m_v;
        retire_wr    = wr_done && ((state_q == ST_WM) || !dst_m_v_q);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = accept_state;
            ST_WE: begin
                if (bus.wr_ready) begin
                    if (dst_m_v_q)   state_d = ST_WM;
                    else if (accept) state_d = accept_state;
                    else             state_d = ST_IDLE;
                end
            end
            ST_WM: begin
                if (bus.wr_ready) state_d = accept ? accept_state : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture and counter next values; capture registers only load on acceptance.
    always_comb begin
        dst_e_v_d = dst_e_v_q;
        dst_e_d   = dst_e_q;
        val_e_d   = val_e_q;
        dst_m_v_d = dst_m_v_q;
        dst_m_d   = dst_m_q;
        val_m_d   = val_m_q;
        if (accept) begin
            dst_e_v_d = dec_e_v;
            dst_e_d   = dec_e;
            val_e_d   = bus.valE;
            dst_m_v_d = dec_m_v;
            dst_m_d   = dec_m;
            val_m_d   = bus.valM;
        end
        // A finishing bundle and a destination-less new one can retire together.
        retired_d = retired_q + {15'd0, retire_now} + {15'd0, retire_wr};
    end

    // Capture registers and retired counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_e_v_q <= 1'b0;
            dst_e_q   <= 4'd0;
            val_e_q   <= '0;
            dst_m_v_q <= 1'b0;
            dst_m_q   <= 4'd0;
            val_m_q   <= '0;
            retired_q <= 16'd0;
        end else begin
            dst_e_v_q <= dst_e_v_d;
            dst_e_q   <= dst_e_d;
            val_e_q   <= val_e_d;
            dst_m_v_q <= dst_m_v_d;
            dst_m_q   <= dst_m_d;
            val_m_q   <= val_m_d;
            retired_q <= retired_d;
        end
    end

    // Outputs decoded from state and captured bundle; all zero while idle.
    always_comb begin
        bus.in_ready = in_ready_c;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = 4'd0;
        bus.wr_data  = '0;
        bus.pending  = '0;
        bus.retired  = retired_q;
        case (state_q)
            ST_WE: begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = dst_e_q;
                bus.wr_data = val_e_q;
                bus.pending = reg_bit(dst_e_q)
                            | (dst_m_v_q ? reg_bit(dst_m_q) : '0);
            end
            ST_WM: begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = dst_m_q;
                bus.wr_data = val_m_q;
                bus.pending = reg_bit(dst_m_q);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Bench for wb_write_sequencer: directed scenarios followed by random bundles,
// checked against a queue of outstanding register writes.
module tb_wb_write_sequencer;
    import y86_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_write_sequencer_if bus();

    wb_write_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  a;
        logic [63:0] d;
        bit          last;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [15:0] ret_exp = 16'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected outputs follow from the writes still owed by the in-flight bundle.
    task automatic check_outputs();
        logic [14:0] pend;
        logic [15:0] oh;
        bit          rdy;
        pend = '0;
        foreach (exp_q[i]) begin
            oh   = 16'h0001 << exp_q[i].a;
            pend = pend | oh[14:0];
        end
        rdy = (exp_q.size() == 0) || ((exp_q.size() == 1) && bus.wr_ready);
        chk("wr_en", 64'(bus.wr_en), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("wr_addr", 64'(bus.wr_addr), 64'(exp_q[0].a));
            chk("wr_data", bus.wr_data, exp_q[0].d);
        end
        chk("pending", 64'(bus.pending), 64'(pend));
        chk("retired", 64'(bus.retired), 64'(ret_exp));
        chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    endtask

    // Advance the reference across one rising edge.
    task automatic model_edge();
        bit         rdy;
        logic [3:0] e, m;
        rdy = (exp_q.size() == 0) || ((exp_q.size() == 1) && bus.wr_ready);
        if (exp_q.size() != 0 && bus.wr_ready) begin
            if (exp_q[0].last) ret_exp++;
            void'(exp_q.pop_front());
        end
        if (bus.in_valid && rdy) begin
            e = RNONE;
            m = RNONE;
            case (bus.icode)
                4'h2:             e = bus.cnd ? bus.rB : RNONE;
                4'h3, 4'h6:       e = bus.rB;
                4'h5:             m = bus.rA;
                4'h8, 4'h9, 4'hA: e = 4'h4;
                4'hB: begin e = 4'h4; m = bus.rA; end
                default: ;
            endcase
            if (e != RNONE) exp_q.push_back('{a: e, d: bus.valE, last: (m == RNONE)});
            if (m != RNONE) exp_q.push_back('{a: m, d: bus.valM, last: 1'b1});
            if (e == RNONE && m == RNONE) ret_exp++;
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] ic, input logic c,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] ve, input logic [63:0] vm, input logic wr);
        bus.in_valid = v;
        bus.icode    = ic;
        bus.cnd      = c;
        bus.rA       = ra;
        bus.rB       = rb;
        bus.valE     = ve;
        bus.valM     = vm;
        bus.wr_ready = wr;
    endtask

    task automatic step(input logic v, input logic [3:0] ic, input logic c,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] ve, input logic [63:0] vm, input logic wr);
        @(negedge clk);
        drive(v, ic, c, ra, rb, ve, vm, wr);
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input logic wr);
        step(1'b0, 4'h0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, wr);
    endtask

    task automatic check_reset_values();
        chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst_wr_data", bus.wr_data, 64'd0);
        chk("rst_pending", 64'(bus.pending), 64'd0);
        chk("rst_retired", 64'(bus.retired), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 1'b1);
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // irmovq rB=3
        step(1'b1, I_IRMOVQ, 1'b0, 4'hF, 4'h3, 64'h1234, 64'd0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // popq rA=7: RSP then 7, in_ready low during first write
        step(1'b1, I_POPQ, 1'b0, 4'h7, 4'hF, 64'h100, 64'hAB, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // popq rA=RSP: two writes to address 4, valM last
        step(1'b1, I_POPQ, 1'b0, 4'h4, 4'hF, 64'h108, 64'h55, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // cmov not taken, nop, OPq rB=2 back to back
        step(1'b1, I_CMOVXX, 1'b0, 4'h1, 4'h1, 64'h77, 64'd0, 1'b1);
        step(1'b1, 4'h1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 1'b1);
        step(1'b1, I_OPQ, 1'b0, 4'h0, 4'h2, 64'hDEAD, 64'd0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // mrmovq rA=5 stalled three cycles while another bundle is offered
        step(1'b1, I_MRMOVQ, 1'b0, 4'h5, 4'hF, 64'd0, 64'h55AA, 1'b1);
        repeat (3) step(1'b1, I_IRMOVQ, 1'b0, 4'hF, 4'h9, 64'h99, 64'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // reset during the first write of a popq
        step(1'b1, I_POPQ, 1'b0, 4'h7, 4'hF, 64'h200, 64'h300, 1'b1);
        @(negedge clk);
        drive(1'b0, 4'h0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0);
        #1;
        check_outputs();
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        ret_exp = 16'd0;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        idle(1'b1);

        // random bundles with random write-port back-pressure
        repeat (3000) begin
            step(($urandom_range(0, 9) < 7),
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)),
                 {$urandom, $urandom},
                 {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0));
        end
        repeat (4) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_write_sequencer.md
# wb_write_sequencer

Sequences write-back bundles from the execute/memory stages onto the register file's single write port, one register write per cycle. Each bundle is decoded into at most two destination writes: dstE carries valE, dstM carries valM. dstE is always written before dstM, so popq into %rsp leaves valM in %rsp. The block also publishes a pending-write scoreboard so decode can detect RAW hazards. It sits between the memory stage and the register file, and replaces direct array writes in the write-back stage.

## Interface
- W, 64, data width
- NREGS, 15, architectural registers 0..14
- RSP, 4, stack-pointer index
- RNONE, 4'hF, "no register" encoding
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  bundle offered
- in_ready  out  1  bundle accepted when in_valid && in_ready at posedge
- icode  in  4  instruction code of bundle
- cnd  in  1  condition result (cmovXX)
- rA, rB  in  4 each  register specifiers
- valE, valM  in  W each  ALU and memory results
- wr_en  out  1  write request to register file
- wr_ready  in  1  register file accepts write this cycle
- wr_addr  out  4  write register index
- wr_data  out  W  write data
- pending  out  NREGS  bit r set while a write to r is captured but not yet completed
- retired  out  16  count of completed bundles, wraps at 2^16

## Operation
- Destination decode, applied at acceptance:
  - 2 (cmovXX): dstE = cnd ? rB : RNONE.
  - 3 (irmovq), 6 (OPq): dstE = rB.
  - 5 (mrmovq): dstM = rA.
  - 8, 9, A (call, ret, pushq): dstE = RSP.
  - B (popq): dstE = RSP, dstM = rA.
  - Every other icode: no destination.
  - Any destination equal to RNONE is dropped.
- Capture registers hold dstE_v, dstE, valE, dstM_v, dstM and valM.
- FSM states are IDLE, WE and WM.
- Next state after an acceptance: WE if dstE_v, otherwise WM if dstM_v, otherwise IDLE. A bundle with no destinations retires in its acceptance cycle.
- WE: wr_en=1, wr_addr=dstE, wr_data=valE.
  - On wr_en && wr_ready: go to WM if dstM_v; otherwise retire and take the acceptance transition, or go to IDLE.
- WM: wr_en=1, wr_addr=dstM, wr_data=valM.
  - On wr_en && wr_ready: retire and take the acceptance transition, or go to IDLE.
- While wr_ready=0: hold the state, keep wr_en/wr_addr/wr_data stable and keep in_ready low.
- in_ready = IDLE || (WE && !dstM_v && wr_ready) || (WM && wr_ready). This gives back-to-back bundles with no bubble.
- pending:
  - In WE: set bit dstE, and also bit dstM if dstM_v.
  - In WM: set bit dstM.
  - In IDLE: all zero.
  - Never reflects the bundle currently on the inputs.
- retired increments by 1 per retiring bundle, including bundles with no destinations.
- popq with rA=RSP writes address 4 twice: valE first, then valM.

## Timing
- Reset values: state IDLE; wr_en 0, wr_addr 0, wr_data 0, pending 0, retired 0, in_ready 1. All capture registers are 0.
- Latency: a bundle accepted at edge N drives wr_en during cycle N+1. The second write is driven no earlier than cycle N+2.
- Throughput: one register write per cycle when wr_ready stays 1.
- Reset asserted mid-bundle: the bundle is dropped, no further writes occur, and retired is not incremented.
- wr_ready is sampled only while wr_en=1.

## Structure
- Shared package y86_pkg holds:
  - icode constants (I_CMOVXX, I_IRMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ).
  - RSP and RNONE.
  - The FSM state enum.
- Combinational sub-module wb_dest_decode (icode, cnd, rA, rB -> dstE_v, dstE, dstM_v, dstM).
- FSM, capture registers and counter live in wb_write_sequencer.

## Test plan
- irmovq rB=3, valE=0x1234, wr_ready=1 → one write (3, 0x1234) in the cycle after acceptance; pending[3] set for that cycle only; retired=1.
- popq rA=7, valE=0x100, valM=0xAB → writes (4, 0x100) then (7, 0xAB) in consecutive cycles; in_ready low during the first write; pending = {4,7} then {7}.
- popq rA=4, valE=0x108, valM=0x55 → two writes to address 4; the final committed value is 0x55.
- cmovXX with cnd=0, then nop, then OPq rB=2 presented back-to-back → no writes for the first two bundles; retired counts 2 immediately; OPq writes address 2.
- mrmovq rA=5 with wr_ready held low for 3 cycles → wr_en, address 5 and data held stable; in_ready stays 0; the write completes on the 4th cycle.
- Assert rst_n during the WE cycle of a popq → no WM write; all outputs return to reset values asynchronously.
